// File: rtl/hazard_pkg.sv
// Shared types and stall-depth constants for the hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] LOAD_USE_STALL = 2'd1;
    localparam logic [1:0] BR_ALU_STALL   = 2'd1;
    localparam logic [1:0] BR_LOAD_STALL  = 2'd2;

    function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational stall-depth calculation: how many bubbles the ID instruction needs.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] IF_IDRs,
    input  logic [4:0] IF_IDRt,
    input  logic       UsesRt,
    input  logic       IsBranchOp,
    input  logic       JumpRegister,
    input  logic [4:0] ID_EXRegdst,
    input  logic       ID_EXRegWrite,
    input  logic       ID_EXMemRead,
    input  logic [4:0] EX_MemRegdst,
    input  logic       EX_MEMRegWrite,
    input  logic       EX_MEMMemRead,
    output logic [1:0] stall_n
);

    logic ex_hit;
    logic mem_hit;
    logic ex_load;
    logic ex_alu;
    logic mem_load;
    logic id_compare;

    // Register $0 never creates a dependency.
    assign ex_hit  = (ID_EXRegdst != 5'd0) &&
                     ((ID_EXRegdst == IF_IDRs) || (UsesRt && (ID_EXRegdst == IF_IDRt)));
    assign mem_hit = (EX_MemRegdst != 5'd0) &&
                     ((EX_MemRegdst == IF_IDRs) || (UsesRt && (EX_MemRegdst == IF_IDRt)));

    assign ex_load    = ID_EXRegWrite && ID_EXMemRead && ex_hit;
    assign ex_alu     = ID_EXRegWrite && !ID_EXMemRead && ex_hit;
    assign mem_load   = EX_MEMRegWrite && EX_MEMMemRead && mem_hit;
    assign id_compare = IsBranchOp || JumpRegister;

    always_comb begin
        stall_n = 2'd0;
        if (ex_load)
            stall_n = max2(stall_n, LOAD_USE_STALL);
        if (id_compare && ex_alu)
            stall_n = max2(stall_n, BR_ALU_STALL);
        if (id_compare && ex_load)
            stall_n = max2(stall_n, BR_LOAD_STALL);
        if (id_compare && mem_load)
            stall_n = max2(stall_n, BR_ALU_STALL);
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: stalls, flushes and optional statistics.
// Optional feature macro: HAZARD_STATS_EN adds StallCycles/FlushCount outputs.
module hazard_sequencer
    import hazard_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  IF_IDRs,
    input  logic [4:0]  IF_IDRt,
    input  logic        UsesRt,
    input  logic        IsBranchOp,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpRegister,
    input  logic [4:0]  ID_EXRegdst,
    input  logic        ID_EXRegWrite,
    input  logic        ID_EXMemRead,
    input  logic [4:0]  EX_MemRegdst,
    input  logic        EX_MEMRegWrite,
    input  logic        EX_MEMMemRead,
    output logic        PCWrite,
    output logic        IF_IDWrite,
    output logic        Stall,
    output logic        IF_Flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    state_t     state, state_next;
    logic [1:0] cnt, cnt_next;
    logic [1:0] stall_n;
    logic       redirect;

    hazard_detect u_detect (
        .IF_IDRs        (IF_IDRs),
        .IF_IDRt        (IF_IDRt),
        .UsesRt         (UsesRt),
        .IsBranchOp     (IsBranchOp),
        .JumpRegister   (JumpRegister),
        .ID_EXRegdst    (ID_EXRegdst),
        .ID_EXRegWrite  (ID_EXRegWrite),
        .ID_EXMemRead   (ID_EXMemRead),
        .EX_MemRegdst   (EX_MemRegdst),
        .EX_MEMRegWrite (EX_MEMRegWrite),
        .EX_MEMMemRead  (EX_MEMMemRead),
        .stall_n        (stall_n)
    );

    assign redirect = Branch || Jump || JumpRegister;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        PCWrite    = 1'b1;
        IF_IDWrite = 1'b1;
        Stall      = 1'b0;
        IF_Flush   = 1'b0;
        case (state)
            RUN, FLUSH: begin
                // A hazard wins over a redirect; FLUSH ignores redirects entirely.
                if (stall_n != 2'd0) begin
                    PCWrite    = 1'b0;
                    IF_IDWrite = 1'b0;
                    Stall      = 1'b1;
                    if (stall_n == 2'd2) begin
                        state_next = STALL;
                        cnt_next   = 2'd1;
                    end else begin
                        state_next = RUN;
                    end
                end else if ((state == RUN) && redirect) begin
                    IF_Flush   = 1'b1;
                    state_next = FLUSH;
                end else begin
                    state_next = RUN;
                end
            end
            STALL: begin
                PCWrite    = 1'b0;
                IF_IDWrite = 1'b0;
                Stall      = 1'b1;
                cnt_next   = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
                if (cnt_next == 2'd0)
                    state_next = RUN;
            end
            default: begin
                state_next = RUN;
                cnt_next   = 2'd0;
            end
        endcase
        if (Reset) begin
            PCWrite    = 1'b1;
            IF_IDWrite = 1'b1;
            Stall      = 1'b0;
            IF_Flush   = 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCycles <= 32'd0;
            FlushCount  <= 32'd0;
        end else begin
            if (Stall && (StallCycles != 32'hFFFF_FFFF))
                StallCycles <= StallCycles + 32'd1;
            if (IF_Flush && (FlushCount != 32'hFFFF_FFFF))
                FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_hazard_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  IF_IDRs, IF_IDRt, ID_EXRegdst, EX_MemRegdst;
    logic        UsesRt, IsBranchOp, Branch, Jump, JumpRegister;
    logic        ID_EXRegWrite, ID_EXMemRead, EX_MEMRegWrite, EX_MEMMemRead;
    logic        PCWrite, IF_IDWrite, Stall, IF_Flush;
`ifdef HAZARD_STATS_EN
    logic [31:0] StallCycles, FlushCount;
`endif

    int tests = 0;
    int fails = 0;

    // Model state: bubbles still owed, and whether the previous cycle issued a flush.
    int          owed = 0;
    bit          shadow = 1'b0;
    longint      m_stalls = 0;
    longint      m_flushes = 0;

    always #5 Clk = ~Clk;

    hazard_sequencer dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .IF_IDRs        (IF_IDRs),
        .IF_IDRt        (IF_IDRt),
        .UsesRt         (UsesRt),
        .IsBranchOp     (IsBranchOp),
        .Branch         (Branch),
        .Jump           (Jump),
        .JumpRegister   (JumpRegister),
        .ID_EXRegdst    (ID_EXRegdst),
        .ID_EXRegWrite  (ID_EXRegWrite),
        .ID_EXMemRead   (ID_EXMemRead),
        .EX_MemRegdst   (EX_MemRegdst),
        .EX_MEMRegWrite (EX_MEMRegWrite),
        .EX_MEMMemRead  (EX_MEMMemRead),
        .PCWrite        (PCWrite),
        .IF_IDWrite     (IF_IDWrite),
        .Stall          (Stall),
        .IF_Flush       (IF_Flush)
`ifdef HAZARD_STATS_EN
        ,
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [4:0] dst);
        if (dst == 5'd0) return 1'b0;
        return (dst == IF_IDRs) || (UsesRt && dst == IF_IDRt);
    endfunction

    // Bubbles demanded by the ID instruction, as the maximum over applicable rules.
    function automatic int needed();
        int  amounts[$];
        int  best = 0;
        bit  cmp_in_id = IsBranchOp || JumpRegister;
        bit  ex_load   = ID_EXRegWrite && ID_EXMemRead && reads(ID_EXRegdst);
        bit  ex_alu    = ID_EXRegWrite && !ID_EXMemRead && reads(ID_EXRegdst);
        bit  mem_load  = EX_MEMRegWrite && EX_MEMMemRead && reads(EX_MemRegdst);
        if (ex_load)              amounts.push_back(1);
        if (cmp_in_id && ex_alu)  amounts.push_back(1);
        if (cmp_in_id && ex_load) amounts.push_back(2);
        if (cmp_in_id && mem_load) amounts.push_back(1);
        foreach (amounts[i]) if (amounts[i] > best) best = amounts[i];
        return best;
    endfunction

    task automatic idle();
        Reset = 1'b0;
        IF_IDRs = 5'd0; IF_IDRt = 5'd0; UsesRt = 1'b0;
        IsBranchOp = 1'b0; Branch = 1'b0; Jump = 1'b0; JumpRegister = 1'b0;
        ID_EXRegdst = 5'd0; ID_EXRegWrite = 1'b0; ID_EXMemRead = 1'b0;
        EX_MemRegdst = 5'd0; EX_MEMRegWrite = 1'b0; EX_MEMMemRead = 1'b0;
    endtask

    // One cycle: check DUT against the model (and optionally a literal), then advance the model.
    task automatic step(input bit lit_en, input logic [3:0] lit);
        logic [3:0] exp;
        logic [3:0] act;
        int n;
        @(negedge Clk);
        #1;
        if (Reset) begin
            exp = 4'b1100;
        end else if (owed > 0) begin
            exp = 4'b0010;
        end else begin
            n = needed();
            if (n > 0)
                exp = 4'b0010;
            else if (!shadow && (Branch || Jump || JumpRegister))
                exp = 4'b1101;
            else
                exp = 4'b1100;
        end
        act = {PCWrite, IF_IDWrite, Stall, IF_Flush};
        chk("outputs_vs_model", {28'd0, act}, {28'd0, exp});
        if (lit_en) begin
            chk("model_vs_literal", {28'd0, exp}, {28'd0, lit});
            chk("outputs_vs_literal", {28'd0, act}, {28'd0, lit});
        end
`ifdef HAZARD_STATS_EN
        chk("stall_cycles", StallCycles, m_stalls[31:0]);
        chk("flush_count", FlushCount, m_flushes[31:0]);
`endif
        if (Reset) begin
            owed = 0; shadow = 1'b0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (exp[1] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            if (exp[0] && m_flushes < 64'hFFFF_FFFF) m_flushes++;
            if (owed > 0)
                owed--;
            else if (exp[1])
                owed = needed() - 1;
            shadow = exp[0];
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic lw_ex(input logic [4:0] r);
        ID_EXRegdst = r; ID_EXRegWrite = 1'b1; ID_EXMemRead = 1'b1;
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        step(1'b1, 4'b1100);
        step(1'b1, 4'b1100);
        Reset = 1'b0;
        step(1'b1, 4'b1100);

        // Load-use: lw $8 in EX, add $9,$8,$10 in ID.
        lw_ex(5'd8); IF_IDRs = 5'd8; IF_IDRt = 5'd10; UsesRt = 1'b1;
        step(1'b1, 4'b0010);
        ID_EXRegdst = 5'd0; ID_EXRegWrite = 1'b0; ID_EXMemRead = 1'b0;
        step(1'b1, 4'b1100);

        // beq after load: two bubbles even though inputs go quiet during STALL.
        idle(); lw_ex(5'd8); IF_IDRs = 5'd8; IF_IDRt = 5'd9; UsesRt = 1'b1; IsBranchOp = 1'b1;
        step(1'b1, 4'b0010);
        idle();
        step(1'b1, 4'b0010);
        step(1'b1, 4'b1100);

        // Jump held high: flush, then no flush in FLUSH, then flush again from RUN.
        idle(); Jump = 1'b1;
        step(1'b1, 4'b1101);
        step(1'b1, 4'b1100);
        step(1'b1, 4'b1101);
        idle();
        step(1'b1, 4'b1100);

        // jr $8 behind add $8: stall first, flush right after.
        JumpRegister = 1'b1; IF_IDRs = 5'd8;
        ID_EXRegdst = 5'd8; ID_EXRegWrite = 1'b1;
        step(1'b1, 4'b0010);
        ID_EXRegdst = 5'd0; ID_EXRegWrite = 1'b0;
        step(1'b1, 4'b1101);
        idle();
        step(1'b1, 4'b1100);

        // Branch behind a load in MEM: single bubble.
        IsBranchOp = 1'b1; IF_IDRs = 5'd3; EX_MemRegdst = 5'd3;
        EX_MEMRegWrite = 1'b1; EX_MEMMemRead = 1'b1;
        step(1'b1, 4'b0010);
        idle();
        step(1'b1, 4'b1100);

        // $0 never stalls.
        lw_ex(5'd0); UsesRt = 1'b1; IsBranchOp = 1'b1;
        step(1'b1, 4'b1100);

        // Reset during STALL aborts it; a jump right after proves RUN.
        idle(); lw_ex(5'd8); IF_IDRs = 5'd8; IsBranchOp = 1'b1;
        step(1'b1, 4'b0010);
        Reset = 1'b1;
        step(1'b1, 4'b1100);
        idle(); Jump = 1'b1;
        step(1'b1, 4'b1101);
`ifdef HAZARD_STATS_EN
        chk("stall_after_reset_lit", StallCycles, 32'd0);
        chk("flush_after_reset_lit", FlushCount, 32'd1);
`endif
        idle();
        step(1'b1, 4'b1100);

        // Random traffic over a small register set so dependencies are frequent.
        for (int i = 0; i < 3000; i++) begin
            Reset          = ($urandom_range(0, 59) == 0);
            IF_IDRs        = 5'($urandom_range(0, 3));
            IF_IDRt        = 5'($urandom_range(0, 3));
            UsesRt         = 1'($urandom);
            IsBranchOp     = ($urandom_range(0, 3) == 0);
            Branch         = IsBranchOp & 1'($urandom);
            Jump           = ($urandom_range(0, 5) == 0);
            JumpRegister   = ($urandom_range(0, 5) == 0);
            ID_EXRegdst    = 5'($urandom_range(0, 3));
            ID_EXRegWrite  = 1'($urandom);
            ID_EXMemRead   = 1'($urandom);
            EX_MemRegdst   = 5'($urandom_range(0, 3));
            EX_MEMRegWrite = 1'($urandom);
            EX_MEMMemRead  = 1'($urandom);
            step(1'b0, 4'b0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
